// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit (radix-2, one bit per cycle).
// MUL/MULH/MULHSU/MULHU use shift-add. DIV/DIVU/REM/REMU use restoring
// shift-subtract. Both work on operand magnitudes, and the sign is fixed up
// on the final step. Divide-by-zero and signed overflow complete straight
// from IDLE in one cycle.
// Ports:
//   clk, rst                    clock, async active-high reset
//   in_valid / in_ready         request handshake (in_ready only in IDLE)
//   MulDivOp, SrcA, SrcB        funct3 op and operands, sampled at accept only
//   flush                       abort in-flight op (RUN/DONE) or ignore a request (IDLE)
//   out_valid / out_ready       response handshake (out_valid only in DONE)
//   Result                      registered result; holds its value after DONE
//   busy                        high in RUN or DONE
module muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            MulDivOp,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] Result,
  output logic                  busy
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      op_q;
  logic [2*W-1:0]  acc_q;    // mul: {partial hi, multiplier}; div: {remainder, dividend/quotient}
  logic [W-1:0]    mcand_q;  // multiplicand or divisor magnitude
  logic            neg_q;    // negate the selected result in the final step
  logic [W-1:0]    result_q;

  // Accept-time decode
  logic         a_signed, b_signed, a_neg, b_neg, is_div, early;
  logic [W-1:0] a_mag, b_mag, early_res;

  always_comb begin
    is_div   = MulDivOp[2];
    a_signed = is_div ? ~MulDivOp[0] : (MulDivOp[1:0] != 2'b11);
    b_signed = is_div ? ~MulDivOp[0] : ~MulDivOp[1];
    a_neg    = a_signed & SrcA[W-1];
    b_neg    = b_signed & SrcB[W-1];
    a_mag    = a_neg ? -SrcA : SrcA;
    b_mag    = b_neg ? -SrcB : SrcB;
    early     = 1'b0;
    early_res = '0;
    if (is_div && SrcB == '0) begin
      early     = 1'b1;
      early_res = MulDivOp[1] ? SrcA : '1;
    end else if (is_div && !MulDivOp[0] && SrcA == {1'b1, {(W-1){1'b0}}} && SrcB == '1) begin
      early     = 1'b1;
      early_res = MulDivOp[1] ? '0 : SrcA;
    end
  end

  // One iteration step
  logic [W:0]     mul_sum, div_shl, div_diff;
  logic [2*W-1:0] mul_nxt, div_nxt, acc_nxt, prod;
  logic [W-1:0]   quo, rem, fix_res;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    mul_nxt  = {mul_sum, acc_q[W-1:1]};
    div_shl  = acc_q[2*W-1:W-1];
    div_diff = div_shl - {1'b0, mcand_q};
    // Borrow out means the trial subtraction failed: keep the shifted remainder.
    if (div_diff[W]) div_nxt = {div_shl[W-1:0], acc_q[W-2:0], 1'b0};
    else             div_nxt = {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
    acc_nxt  = op_q[2] ? div_nxt : mul_nxt;
    prod     = neg_q ? -acc_nxt : acc_nxt;
    quo      = neg_q ? -acc_nxt[W-1:0] : acc_nxt[W-1:0];
    rem      = neg_q ? -acc_nxt[2*W-1:W] : acc_nxt[2*W-1:W];
    if (op_q[2])                fix_res = op_q[1] ? rem : quo;
    else if (op_q[1:0] == 2'b00) fix_res = prod[W-1:0];
    else                        fix_res = prod[2*W-1:W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else if (flush) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          op_q <= MulDivOp;
          if (early) begin
            result_q <= early_res;
            state_q  <= DONE;
          end else begin
            cnt_q   <= CW'(W);
            // Remainder follows the dividend's sign; quotient/product the sign xor.
            neg_q   <= (is_div && MulDivOp[1]) ? a_neg : (a_neg ^ b_neg);
            mcand_q <= is_div ? b_mag : a_mag;
            acc_q   <= {{W{1'b0}}, (is_div ? a_mag : b_mag)};
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q <= acc_nxt;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            result_q <= fix_res;
            state_q  <= DONE;
          end
        end
        DONE: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign Result    = result_q;
endmodule
